// File: rtl/vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_mem_arbiter
//  Description : Arbitrates a single-port synchronous pixel memory between the
//                VGA scan-out fetch path and a host read/write port. VGA
//                fetches always win. Host writes are buffered in a small FIFO
//                that drains in idle memory cycles. A host read is only
//                granted once every earlier accepted write has landed, so it
//                always observes all prior writes.
//  Ports       : clock/reset      - system clock, async active-high reset
//                vga_*            - VGA fetch request and returned pixel
//                host_wr_*        - host write channel (valid/ready)
//                host_rd_*        - host read channel (valid/ready, rvalid)
//                mem_*            - frame memory port (1-cycle read latency)
//                fifo_level       - write buffer occupancy
//                stall_cnt        - saturating count of VGA-blocked host cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_mem_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  // VGA fetch path
  input  logic                          vga_req,
  input  logic [ADDR_W-1:0]             vga_addr,
  output logic [DATA_W-1:0]             vga_data,
  output logic                          vga_valid,
  // Host write channel
  input  logic                          host_wr_valid,
  output logic                          host_wr_ready,
  input  logic [ADDR_W-1:0]             host_wr_addr,
  input  logic [DATA_W-1:0]             host_wr_data,
  // Host read channel
  input  logic                          host_rd_valid,
  output logic                          host_rd_ready,
  input  logic [ADDR_W-1:0]             host_rd_addr,
  output logic [DATA_W-1:0]             host_rd_data,
  output logic                          host_rd_rvalid,
  // Frame memory port
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  // Status
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Write buffer storage (data only; occupancy tracked by r_level)
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_vga_valid;
  logic              r_rd_rvalid;
  logic [15:0]       r_stall;

  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_gnt_vga;
  logic              w_gnt_wr;
  logic              w_gnt_rd;
  logic              w_stall_inc;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));

  // No pass-through when full: ready depends only on the current level.
  assign host_wr_ready = !reset && !w_full;
  assign w_push        = host_wr_valid && host_wr_ready;

  // Fixed-priority grant: VGA > buffered write > host read > idle.
  // A read needs an empty buffer and no write handshake this cycle, since
  // such a write is older than the read and must land first.
  always_comb begin
    w_gnt_vga = 1'b0;
    w_gnt_wr  = 1'b0;
    w_gnt_rd  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      if (vga_req) begin
        w_gnt_vga = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = vga_addr;
      end else if (!w_empty) begin
        w_gnt_wr  = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_fifo_addr[r_rd_ptr];
        mem_wdata = r_fifo_data[r_rd_ptr];
      end else if (host_rd_valid && !w_push) begin
        w_gnt_rd  = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = host_rd_addr;
      end
    end
  end

  assign host_rd_ready = w_gnt_rd;

  // VGA occupying the memory while host work is waiting.
  assign w_stall_inc = w_gnt_vga && (!w_empty || host_rd_valid);

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= host_wr_addr;
      r_fifo_data[r_wr_ptr] <= host_wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_vga_valid <= 1'b0;
      r_rd_rvalid <= 1'b0;
      r_stall     <= '0;
    end else begin
      r_vga_valid <= w_gnt_vga;
      r_rd_rvalid <= w_gnt_rd;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_gnt_wr) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_gnt_wr) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_push && w_gnt_wr) begin
        r_level <= r_level - LVL_W'(1);
      end
      if (w_stall_inc && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end

  // Both read paths see the raw memory output; the tags tell who owns it.
  assign vga_data       = mem_rdata;
  assign host_rd_data   = mem_rdata;
  assign vga_valid      = r_vga_valid;
  assign host_rd_rvalid = r_rd_rvalid;
  assign fifo_level     = r_level;
  assign stall_cnt      = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_vga_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_mem_arbiter
//  Description : Self-checking bench for vga_mem_arbiter with a behavioural
//                frame memory, a table of hand-derived vectors, reset corner
//                sequences and a randomized run against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_req;
  logic [3:0] vga_addr;
  logic [7:0] vga_data;
  logic       vga_valid;
  logic       host_wr_valid;
  logic       host_wr_ready;
  logic [3:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       host_rd_valid;
  logic       host_rd_ready;
  logic [3:0] host_rd_addr;
  logic [7:0] host_rd_data;
  logic       host_rd_rvalid;
  logic       mem_en;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [2:0] fifo_level;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clock(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_valid(host_rd_valid), .host_rd_ready(host_rd_ready),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data), .host_rd_rvalid(host_rd_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level), .stall_cnt(stall_cnt)
  );

  // Synchronous frame memory, 1-cycle read latency; load preloads mem[i]=16*i
  logic [7:0] mem [16];
  logic       load;
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(16 * i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    vga_req = 0; vga_addr = 0;
    host_wr_valid = 0; host_wr_addr = 0; host_wr_data = 0;
    host_rd_valid = 0; host_rd_addr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1; load = 1;
    repeat (2) @(posedge clk);
    #1;
    load = 0; reset = 0;
  endtask

  typedef struct {
    int vr, va, wv, wa, wd, rv, ra;               // inputs
    int en, we, ad, wdat, wrdy, rrdy, lvl;        // combinational / level
    int vv, rvv, dat, stl;                        // registered responses
  } vec_t;

  vec_t tbl [16];

  typedef struct { int a; int d; } wr_t;
  wr_t wq[$];
  int  pmem [16];   // physical memory contents
  int  lmem [16];   // memory as seen by a host after all accepted writes

  initial begin
    // ---------------- reset then idle ----------------
    idle_inputs();
    reset = 1; load = 1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_wr_ready", host_wr_ready, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_vga_valid", vga_valid, 0);
    @(posedge clk); #1;
    load = 0; reset = 0;
    @(negedge clk);
    chk("post_rst_wr_ready", host_wr_ready, 1);
    chk("post_rst_mem_en", mem_en, 0);
    @(posedge clk); #1;

    // ---------------- VGA only sweep ----------------
    for (int a = 0; a < 16; a++) begin
      vga_req = 1; vga_addr = 4'(a);
      @(negedge clk);
      chk("vga_mem_en", mem_en, 1);
      chk("vga_mem_we", mem_we, 0);
      chk("vga_mem_addr", mem_addr, a);
      chk("vga_rd_ready", host_rd_ready, 0);
      @(posedge clk); #1;
      vga_req = 0;
      @(negedge clk);
      chk("vga_valid", vga_valid, 1);
      chk("vga_data", vga_data, 16 * a);
      chk("vga_no_rvalid", host_rd_rvalid, 0);
      @(posedge clk); #1;
    end
    chk("vga_only_stall", stall_cnt, 0);

    // ---------------- table: fill, full push/pop, drain, RAW ----------------
    //            vr va wv wa wd    rv ra  en we ad wdat  wrdy rrdy lvl vv rvv dat   stl
    tbl[0]  = '{1, 2, 1, 1, 'h11, 0, 0,  1, 0, 2, 0,    1,   0,   0,  0, 0,  0,    0};
    tbl[1]  = '{1, 3, 1, 2, 'h22, 0, 0,  1, 0, 3, 0,    1,   0,   1,  1, 0,  32,   0};
    tbl[2]  = '{1, 4, 1, 3, 'h33, 0, 0,  1, 0, 4, 0,    1,   0,   2,  1, 0,  48,   1};
    tbl[3]  = '{1, 5, 1, 4, 'h44, 0, 0,  1, 0, 5, 0,    1,   0,   3,  1, 0,  64,   2};
    tbl[4]  = '{1, 6, 1, 5, 'h55, 0, 0,  1, 0, 6, 0,    0,   0,   4,  1, 0,  80,   3};
    tbl[5]  = '{0, 0, 1, 5, 'h55, 0, 0,  1, 1, 1, 'h11, 0,   0,   4,  1, 0,  96,   4};
    tbl[6]  = '{0, 0, 1, 5, 'h55, 0, 0,  1, 1, 2, 'h22, 1,   0,   3,  0, 0,  0,    4};
    tbl[7]  = '{0, 0, 0, 0, 0,    1, 1,  1, 1, 3, 'h33, 1,   0,   3,  0, 0,  0,    4};
    tbl[8]  = '{0, 0, 0, 0, 0,    1, 1,  1, 1, 4, 'h44, 1,   0,   2,  0, 0,  0,    4};
    tbl[9]  = '{0, 0, 0, 0, 0,    1, 1,  1, 1, 5, 'h55, 1,   0,   1,  0, 0,  0,    4};
    tbl[10] = '{0, 0, 0, 0, 0,    1, 1,  1, 0, 1, 0,    1,   1,   0,  0, 0,  0,    4};
    tbl[11] = '{0, 0, 0, 0, 0,    0, 0,  0, 0, 0, 0,    1,   0,   0,  0, 1,  'h11, 4};
    tbl[12] = '{0, 0, 1, 3, 'hA5, 1, 3,  0, 0, 0, 0,    1,   0,   0,  0, 0,  0,    4};
    tbl[13] = '{0, 0, 0, 0, 0,    1, 3,  1, 1, 3, 'hA5, 1,   0,   1,  0, 0,  0,    4};
    tbl[14] = '{0, 0, 0, 0, 0,    1, 3,  1, 0, 3, 0,    1,   1,   0,  0, 0,  0,    4};
    tbl[15] = '{0, 0, 0, 0, 0,    0, 0,  0, 0, 0, 0,    1,   0,   0,  0, 1,  'hA5, 4};

    for (int i = 0; i < 16; i++) begin
      vga_req = 1'(tbl[i].vr); vga_addr = 4'(tbl[i].va);
      host_wr_valid = 1'(tbl[i].wv); host_wr_addr = 4'(tbl[i].wa); host_wr_data = 8'(tbl[i].wd);
      host_rd_valid = 1'(tbl[i].rv); host_rd_addr = 4'(tbl[i].ra);
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].en);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].we);
      chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].ad);
      chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].wdat);
      chk($sformatf("tbl%0d_wr_ready", i), host_wr_ready, tbl[i].wrdy);
      chk($sformatf("tbl%0d_rd_ready", i), host_rd_ready, tbl[i].rrdy);
      chk($sformatf("tbl%0d_level", i), fifo_level, tbl[i].lvl);
      chk($sformatf("tbl%0d_vga_valid", i), vga_valid, tbl[i].vv);
      chk($sformatf("tbl%0d_rd_rvalid", i), host_rd_rvalid, tbl[i].rvv);
      if (tbl[i].vv != 0) chk($sformatf("tbl%0d_vga_data", i), vga_data, tbl[i].dat);
      if (tbl[i].rvv != 0) chk($sformatf("tbl%0d_rd_data", i), host_rd_data, tbl[i].dat);
      chk($sformatf("tbl%0d_stall", i), stall_cnt, tbl[i].stl);
      @(posedge clk); #1;
    end
    idle_inputs();

    // ---------------- reset mid-operation ----------------
    vga_req = 1; vga_addr = 7;
    host_wr_valid = 1; host_wr_addr = 8; host_wr_data = 8'h77;
    @(posedge clk); #1;
    host_wr_addr = 9; host_wr_data = 8'h99;
    @(posedge clk); #1;
    idle_inputs();
    host_rd_valid = 1;
    #1;
    chk("mid_level_before", fifo_level, 2);
    chk("mid_vga_pending", vga_valid, 1);
    chk("mid_write_pending", mem_en, 1);
    reset = 1;
    #1;
    chk("mid_rst_level", fifo_level, 0);
    chk("mid_rst_vga_valid", vga_valid, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_wr_ready", host_wr_ready, 0);
    chk("mid_rst_rd_ready", host_rd_ready, 0);
    @(posedge clk); #1;
    reset = 0;
    host_rd_valid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_mid_mem_en", mem_en, 0);
      chk("post_mid_level", fifo_level, 0);
      @(posedge clk); #1;
    end
    chk("post_mid_mem8", mem[8], 128);
    chk("post_mid_mem9", mem[9], 144);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int i = 0; i < 16; i++) begin
      pmem[i] = 16 * i;
      lmem[i] = 16 * i;
    end
    begin
      bit rd_act = 0;
      bit pv = 0, pr = 0;
      int ev = 0, er = 0, stall = 0;
      for (int c = 0; c < 3000; c++) begin
        bit e_wrdy, push, gv, gw, gr, e_en, e_we;
        int e_ad, e_wd, qn;
        vga_req       = ($urandom_range(0, 2) == 0);
        vga_addr      = 4'($urandom);
        if (!rd_act && $urandom_range(0, 3) == 0) begin
          rd_act = 1;
          host_rd_addr = 4'($urandom);
        end
        host_rd_valid = rd_act;
        host_wr_valid = 1'($urandom_range(0, 1));
        host_wr_addr  = 4'($urandom);
        host_wr_data  = 8'($urandom);
        @(negedge clk);
        qn     = wq.size();
        e_wrdy = (qn < 4);
        push   = host_wr_valid && e_wrdy;
        gv = vga_req;
        gw = !gv && (qn > 0);
        gr = !gv && !gw && rd_act && !push;
        e_en = gv || gw || gr;
        e_we = gw;
        e_ad = gv ? int'(vga_addr) : gw ? wq[0].a : gr ? int'(host_rd_addr) : 0;
        e_wd = gw ? wq[0].d : 0;
        chk("rnd_mem_en", mem_en, e_en);
        chk("rnd_mem_we", mem_we, e_we);
        chk("rnd_mem_addr", mem_addr, e_ad);
        chk("rnd_mem_wdata", mem_wdata, e_wd);
        chk("rnd_wr_ready", host_wr_ready, e_wrdy);
        chk("rnd_rd_ready", host_rd_ready, gr);
        chk("rnd_level", fifo_level, qn);
        chk("rnd_stall", stall_cnt, stall);
        chk("rnd_vga_valid", vga_valid, pv);
        chk("rnd_rd_rvalid", host_rd_rvalid, pr);
        if (pv) chk("rnd_vga_data", vga_data, ev);
        if (pr) chk("rnd_rd_data", host_rd_data, er);
        if (gv && (qn > 0 || rd_act) && stall < 65535) stall++;
        pv = gv; pr = gr;
        if (gv) ev = pmem[vga_addr];
        if (gr) begin
          er = lmem[host_rd_addr];
          rd_act = 0;
        end
        if (gw) begin
          pmem[wq[0].a] = wq[0].d;
          void'(wq.pop_front());
        end
        if (push) begin
          lmem[host_wr_addr] = host_wr_data;
          wq.push_back('{int'(host_wr_addr), int'(host_wr_data)});
        end
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Arbitrates the single-port pixel memory between the VGA scan-out engine (`vga_from_mem` address/data path) and a host port that writes and reads pixel bytes. VGA fetches always win; host writes are buffered in a small FIFO and drained in idle memory cycles; host reads wait until all earlier writes have landed. The block sits between `vga_from_mem`, the host logic and the synchronous frame memory, which has a 1-cycle read latency.

## Interface
Parameters:
- `ADDR_W`, 4, memory address width
- `DATA_W`, 8, pixel/memory data width
- `FIFO_DEPTH`, 4, write buffer entries; power of 2, at least 2

Ports:
- `clock`  in  1  system clock, all logic on posedge
- `reset`  in  1  asynchronous, active-high reset
- `vga_req`  in  1  VGA fetch request this cycle
- `vga_addr`  in  ADDR_W  VGA fetch address
- `vga_data`  out  DATA_W  fetched pixel, equal to `mem_rdata`
- `vga_valid`  out  1  `vga_data` valid (registered)
- `host_wr_valid`  in  1  host write request
- `host_wr_ready`  out  1  write accepted when valid && ready
- `host_wr_addr`  in  ADDR_W  write address
- `host_wr_data`  in  DATA_W  write data
- `host_rd_valid`  in  1  host read request
- `host_rd_ready`  out  1  read accepted (granted) when valid && ready
- `host_rd_addr`  in  ADDR_W  read address
- `host_rd_data`  out  DATA_W  read result, equal to `mem_rdata`
- `host_rd_rvalid`  out  1  `host_rd_data` valid (registered)
- `mem_en`  out  1  memory access this cycle
- `mem_we`  out  1  write strobe
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after a read
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  entries currently buffered
- `stall_cnt`  out  16  saturating count of cycles in which VGA blocked pending host work

## Operation
- The per-cycle grant is combinational from the current inputs and state. Priority order:
  1. VGA: `vga_req`. Drives `mem_en`=1, `mem_we`=0, `mem_addr`=`vga_addr`.
  2. WR: FIFO not empty. Drives `mem_en`=1, `mem_we`=1, address and data from the FIFO head. The FIFO pops at the clock edge.
  3. RD: `host_rd_valid`, FIFO empty, and no write handshake in the same cycle. Drives `host_rd_ready`=1, `mem_en`=1, `mem_we`=0, `mem_addr`=`host_rd_addr`.
  4. Otherwise `mem_en`=0. `mem_we`, `mem_addr` and `mem_wdata` are then 0.
- Write FIFO:
  - `host_wr_ready` = !full. There is no pass-through when full, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave `fifo_level` unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: a write handshaked in the same cycle as a read request is older than that read. Every host read returns data that includes all previously accepted writes.
- Read responses:
  - `vga_valid` and `host_rd_rvalid` are registered tags of the previous cycle's VGA and RD grants. At most one is high.
  - `vga_data` and `host_rd_data` both mirror `mem_rdata`.
- `stall_cnt` increments when the grant is VGA and either (FIFO not empty) or `host_rd_valid`. It saturates at 16'hFFFF.
- While `reset` is high: `host_wr_ready`=0, `host_rd_ready`=0, `mem_en`=0.

## Timing
- Reset values: FIFO empty, `fifo_level`=0, `vga_valid`=0, `host_rd_rvalid`=0, `stall_cnt`=0. Pointers are 0.
- VGA latency: request in cycle N, grant in N, `vga_valid`=1 with the data in N+1. Back-to-back requests produce back-to-back data.
- Host write: handshake in N, entry visible in `fifo_level` at N+1. The earliest memory write is in N+1 if `vga_req` is low.
- Host read: granted in cycle G, data in G+1. `host_rd_valid` and `host_rd_addr` must stay stable until ready.
- Continuous `vga_req` starves the host indefinitely. This is by design; the VGA engine requests at most every other cycle (half-rate vga_clock).
- Reset asserted mid-operation:
  - FIFO contents are discarded immediately (asynchronous).
  - Pending response tags clear.
  - Any memory write in flight that cycle is suppressed because `mem_en` is forced to 0.

## Test plan
- Reset then idle: `mem_en`=0, `fifo_level`=0, `host_wr_ready`=0 during reset and 1 after release, `stall_cnt`=0.
- VGA only: `vga_req` high every other cycle over addr 0..15, memory preloaded with `mem[i]`=16*i -> `vga_valid` one cycle later with `vga_data`=16*addr, and no host grants.
- Fill FIFO while `vga_req` is held high: 4 writes accepted, the 5th sees `host_wr_ready`=0 and `fifo_level`=4. `stall_cnt` increments each blocked cycle. After `vga_req` drops, 4 consecutive memory writes in FIFO order and `fifo_level` returns to 0.
- Read-after-write ordering: write addr 3 = 8'hA5, and in the same cycle assert read addr 3 -> read is not granted until the write is performed. `host_rd_rvalid` returns 8'hA5.
- Simultaneous push/pop at full (vga idle, FIFO full, `host_wr_valid` high) -> `host_wr_ready`=0, one pop, next cycle `host_wr_ready`=1 and `fifo_level`=3.
- Reset asserted while the FIFO holds 2 entries and a VGA response is pending -> `fifo_level`=0, `vga_valid`=0 immediately, and no memory write occurs after reset release.
